// File: rtl/spi_slave_stream.sv
// SPI slave for all four SPI modes with DATA_W-bit words and multi-word frames.
// Received words queue in a registered RX FIFO; a status word is shifted out on MISO.
module spi_slave_stream #(
  parameter int DATA_W      = 8,
  parameter int FIFO_DEPTH  = 4,
  parameter int SYNC_STAGES = 2,
  parameter bit CPOL        = 1'b0,
  parameter bit CPHA        = 1'b0
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          i_sck,
  input  logic                          i_ss,
  input  logic                          i_mosi,
  output logic                          o_miso,
  output logic                          o_miso_oe,
  input  logic [DATA_W-1:0]             i_tx_data,
  output logic [DATA_W-1:0]             o_rx_data,
  output logic                          o_rx_valid,
  input  logic                          i_rx_ready,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level,
  output logic                          o_busy,
  output logic                          o_frame_err,
  output logic                          o_overrun,
  input  logic                          i_clr_err
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);
  localparam logic [PTR_W:0]   FULL_LVL = (PTR_W + 1)'(FIFO_DEPTH);

  typedef enum logic {
    ST_IDLE,
    ST_SHIFT
  } state_t;

  // Synchronisers, delayed copies for edge detection, and power-up arming
  logic [SYNC_STAGES-1:0] r_sck_sync;
  logic [SYNC_STAGES-1:0] r_ss_sync;
  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic [SYNC_STAGES-1:0] r_warm;
  logic                   r_sck_d;
  logic                   r_ss_d;
  logic                   r_armed;

  logic w_sck_s;
  logic w_ss_s;
  logic w_mosi_s;
  logic w_lead_edge;
  logic w_trail_edge;
  logic w_sample_edge;
  logic w_shift_edge;
  logic w_ss_fall;
  logic w_ss_rise;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sck_sync  <= {SYNC_STAGES{CPOL}};
      r_ss_sync   <= '1;
      r_mosi_sync <= '0;
      r_warm      <= '0;
      r_sck_d     <= CPOL;
      r_ss_d      <= 1'b1;
      r_armed     <= 1'b0;
    end else begin
      r_sck_sync  <= {r_sck_sync[SYNC_STAGES-2:0], i_sck};
      r_ss_sync   <= {r_ss_sync[SYNC_STAGES-2:0], i_ss};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], i_mosi};
      r_warm      <= {r_warm[SYNC_STAGES-2:0], 1'b1};
      r_sck_d     <= w_sck_s;
      r_ss_d      <= w_ss_s;
      if (r_warm[SYNC_STAGES-1] && w_ss_s) begin
        r_armed <= 1'b1;
      end
    end
  end

  assign w_sck_s  = r_sck_sync[SYNC_STAGES-1];
  assign w_ss_s   = r_ss_sync[SYNC_STAGES-1];
  assign w_mosi_s = r_mosi_sync[SYNC_STAGES-1];

  assign w_lead_edge   = (r_sck_d == CPOL) && (w_sck_s != CPOL);
  assign w_trail_edge  = (r_sck_d != CPOL) && (w_sck_s == CPOL);
  assign w_sample_edge = CPHA ? w_trail_edge : w_lead_edge;
  assign w_shift_edge  = CPHA ? w_lead_edge : w_trail_edge;

  // A frame already running when reset released must not be joined, so
  // SS is only honoured once it has been seen high after the synchroniser flushed.
  assign w_ss_fall = r_armed && r_ss_d && !w_ss_s;
  assign w_ss_rise = !r_ss_d && w_ss_s;

  // Shift-register FSM
  state_t               r_state;
  logic [DATA_W-1:0]    r_tx_shift;
  logic [DATA_W-1:0]    r_rx_shift;
  logic [CNT_W-1:0]     r_bit_cnt;
  logic                 r_first_edge;
  logic                 r_busy;
  logic                 r_frame_err;

  logic                 w_word_done;
  logic [DATA_W-1:0]    w_push_data;

  assign w_word_done = (r_state == ST_SHIFT) && w_sample_edge && (r_bit_cnt == LAST_BIT);
  assign w_push_data = {r_rx_shift[DATA_W-2:0], w_mosi_s};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= ST_IDLE;
      r_tx_shift   <= '0;
      r_rx_shift   <= '0;
      r_bit_cnt    <= '0;
      r_first_edge <= 1'b0;
      r_busy       <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_frame_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_bit_cnt <= '0;
          r_busy    <= 1'b0;
          if (w_ss_fall) begin
            r_state      <= ST_SHIFT;
            r_tx_shift   <= i_tx_data;
            r_first_edge <= 1'b1;
            r_busy       <= 1'b1;
          end
        end
        ST_SHIFT: begin
          if (w_sample_edge) begin
            r_rx_shift <= w_push_data;
            if (r_bit_cnt == LAST_BIT) begin
              r_bit_cnt    <= '0;
              r_tx_shift   <= i_tx_data;
              r_first_edge <= CPHA;
            end else begin
              r_bit_cnt <= r_bit_cnt + CNT_W'(1);
            end
          end else if (w_shift_edge) begin
            if (CPHA && r_first_edge) begin
              r_first_edge <= 1'b0;
            end else begin
              r_tx_shift <= r_tx_shift << 1;
            end
          end
          // A word completing in the same cycle as SS release is kept, not flagged
          if (w_ss_rise) begin
            r_state     <= ST_IDLE;
            r_busy      <= 1'b0;
            r_tx_shift  <= '0;
            r_bit_cnt   <= '0;
            r_frame_err <= (r_bit_cnt != '0) && !w_word_done;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_miso      = r_tx_shift[DATA_W-1];
  assign o_miso_oe   = r_busy;
  assign o_busy      = r_busy;
  assign o_frame_err = r_frame_err;

  // RX FIFO: registered, pointers wrap naturally because depth is a power of two
  logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W:0]    r_count;
  logic              r_overrun;

  logic w_full;
  logic w_pop;
  logic w_wr;
  logic w_drop;

  assign w_full = (r_count == FULL_LVL);
  assign w_pop  = (r_count != '0) && i_rx_ready;
  assign w_wr   = w_word_done && (!w_full || w_pop);
  assign w_drop = w_word_done && w_full && !w_pop;

  always_ff @(posedge i_clk) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= w_push_data;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_overrun <= 1'b0;
    end else begin
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + (PTR_W + 1)'(1);
        2'b01:   r_count <= r_count - (PTR_W + 1)'(1);
        default: r_count <= r_count;
      endcase
      if (w_drop) begin
        r_overrun <= 1'b1;
      end else if (i_clr_err) begin
        r_overrun <= 1'b0;
      end
    end
  end

  assign o_rx_valid   = (r_count != '0);
  assign o_rx_data    = (r_count != '0) ? r_mem[r_rd_ptr] : '0;
  assign o_fifo_level = r_count;
  assign o_overrun    = r_overrun;

endmodule

// File: tb/tb_spi_slave_stream.sv
// Bench for spi_slave_stream: one DUT per SPI mode, bit-banged master, queue-based model.
// Instance 0 (mode 0) carries the FIFO/error scenarios; instances 1-3 cover the mode sweep.
module tb_spi_slave_stream;

  localparam int H = 6;

  typedef logic [7:0] byte_q_t[$];

  logic       clk;
  logic       rst_n;
  logic       mosi;
  logic [7:0] tx_data;
  logic       clr_err;
  logic [3:0] sck_v;
  logic [3:0] ss_v;
  logic [3:0] rdy_v;
  logic [3:0] miso_v;
  logic [3:0] oe_v;
  logic [3:0] valid_v;
  logic [3:0] busy_v;
  logic [3:0] ferr_v;
  logic [3:0] ovr_v;
  logic [7:0] rxd_v [4];
  logic [2:0] lvl_v [4];

  int compared   = 0;
  int mismatched = 0;
  int ferrSeen   = 0;
  int ferrExp    = 0;
  bit ovrModel   = 1'b0;
  logic [7:0] q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    spi_slave_stream #(
      .DATA_W(8), .FIFO_DEPTH(4), .SYNC_STAGES(2),
      .CPOL(1'(g / 2)), .CPHA(1'(g % 2))
    ) u_dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_sck(sck_v[g]), .i_ss(ss_v[g]), .i_mosi(mosi),
      .o_miso(miso_v[g]), .o_miso_oe(oe_v[g]), .i_tx_data(tx_data),
      .o_rx_data(rxd_v[g]), .o_rx_valid(valid_v[g]), .i_rx_ready(rdy_v[g]),
      .o_fifo_level(lvl_v[g]), .o_busy(busy_v[g]), .o_frame_err(ferr_v[g]),
      .o_overrun(ovr_v[g]), .i_clr_err(clr_err)
    );
  end

  always @(posedge clk) begin
    if (ferr_v[0] === 1'b1) ferrSeen++;
  end

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic waitClk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // A completed word enters the model queue unless the 4-entry FIFO is full
  task automatic modelWord(input logic [7:0] w);
    if (q.size() < 4) q.push_back(w);
    else ovrModel = 1'b1;
  endtask

  task automatic spiStart(input int m);
    ss_v[m] = 1'b0;
    waitClk(H);
  endtask

  task automatic spiEnd(input int m);
    waitClk(H);
    ss_v[m] = 1'b1;
    waitClk(8);
  endtask

  task automatic spiBits(input int m, input logic [7:0] w, input int nbits, output logic [7:0] mi);
    logic cpol;
    logic cpha;
    cpol = m[1];
    cpha = m[0];
    mi = '0;
    for (int i = 0; i < nbits; i++) begin
      if (!cpha) begin
        mosi = w[7-i];
        waitClk(H);
        mi[7-i] = miso_v[m];
        sck_v[m] = ~cpol;
        waitClk(H);
        sck_v[m] = cpol;
      end else begin
        sck_v[m] = ~cpol;
        mosi = w[7-i];
        waitClk(H);
        mi[7-i] = miso_v[m];
        sck_v[m] = cpol;
        waitClk(H);
      end
    end
  endtask

  // One SS frame: full words, then optionally a truncated word of trunc bits
  task automatic applyStimulus(input int m, input byte_q_t words, input int trunc, input logic [7:0] tx);
    logic [7:0] mi;
    tx_data = tx;
    spiStart(m);
    foreach (words[k]) begin
      spiBits(m, words[k], 8, mi);
      if (k == 0) begin
        checkOutput($sformatf("miso_word0_m%0d", m), mi, tx);
        checkOutput($sformatf("miso_oe_m%0d", m), oe_v[m], 1'b1);
      end
      if (m == 0) modelWord(words[k]);
    end
    if (trunc > 0) begin
      spiBits(m, 8'($urandom), trunc, mi);
      if (m == 0) ferrExp++;
    end
    spiEnd(m);
  endtask

  task automatic checkFifo(input string tag);
    checkOutput({tag, "_level"}, lvl_v[0], q.size());
    checkOutput({tag, "_valid"}, valid_v[0], q.size() != 0);
    if (q.size() != 0) checkOutput({tag, "_rx_data"}, rxd_v[0], q[0]);
    checkOutput({tag, "_overrun"}, ovr_v[0], ovrModel);
    checkOutput({tag, "_frame_err_cycles"}, ferrSeen, ferrExp);
    checkOutput({tag, "_busy"}, busy_v[0], 1'b0);
  endtask

  task automatic popOne(input string tag);
    checkFifo(tag);
    rdy_v[0] = 1'b1;
    waitClk(1);
    rdy_v[0] = 1'b0;
    void'(q.pop_front());
    waitClk(1);
  endtask

  task automatic clearErr();
    clr_err = 1'b1;
    waitClk(1);
    clr_err = 1'b0;
    ovrModel = 1'b0;
    waitClk(1);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_miso"}, miso_v[0], 1'b0);
    checkOutput({tag, "_miso_oe"}, oe_v[0], 1'b0);
    checkOutput({tag, "_rx_data"}, rxd_v[0], 8'h00);
    checkOutput({tag, "_rx_valid"}, valid_v[0], 1'b0);
    checkOutput({tag, "_level"}, lvl_v[0], 3'd0);
    checkOutput({tag, "_busy"}, busy_v[0], 1'b0);
    checkOutput({tag, "_frame_err"}, ferr_v[0], 1'b0);
    checkOutput({tag, "_overrun"}, ovr_v[0], 1'b0);
  endtask

  initial begin
    byte_q_t    wq;
    logic [7:0] mi;
    int         n;
    int         trunc;

    rst_n   = 1'b0;
    sck_v   = 4'b1100;
    ss_v    = 4'b1111;
    rdy_v   = 4'b0000;
    mosi    = 1'b0;
    tx_data = 8'h00;
    clr_err = 1'b0;
    waitClk(3);
    checkResetOutputs("reset");
    rst_n = 1'b1;
    waitClk(5);

    $display("[TB] mode 0 single word");
    wq.delete(); wq.push_back(8'hA5);
    applyStimulus(0, wq, 0, 8'h3C);
    checkFifo("single");
    popOne("single_pop");
    checkFifo("single_empty");

    $display("[TB] three words in one frame");
    wq.delete(); wq.push_back(8'h01); wq.push_back(8'h02); wq.push_back(8'h03);
    applyStimulus(0, wq, 0, 8'($urandom));
    checkFifo("multi");
    for (int i = 0; i < 3; i++) popOne($sformatf("multi_pop%0d", i));
    checkFifo("multi_empty");

    $display("[TB] truncated frame");
    wq.delete();
    applyStimulus(0, wq, 5, 8'($urandom));
    checkFifo("trunc");
    wq.delete(); wq.push_back(8'h7E);
    applyStimulus(0, wq, 0, 8'($urandom));
    popOne("after_trunc");

    $display("[TB] overrun");
    wq.delete();
    for (int i = 1; i <= 5; i++) wq.push_back(8'(i * 8'h11));
    applyStimulus(0, wq, 0, 8'($urandom));
    checkFifo("ovr_full");
    clearErr();
    checkFifo("ovr_clr");
    for (int i = 0; i < 4; i++) popOne($sformatf("ovr_pop%0d", i));
    checkFifo("ovr_empty");

    $display("[TB] mode sweep");
    for (int m = 1; m < 4; m++) begin
      wq.delete(); wq.push_back(8'hA5);
      applyStimulus(m, wq, 0, 8'h3C);
      checkOutput($sformatf("mode%0d_rx_data", m), rxd_v[m], 8'hA5);
      checkOutput($sformatf("mode%0d_valid", m), valid_v[m], 1'b1);
      checkOutput($sformatf("mode%0d_level", m), lvl_v[m], 3'd1);
      checkOutput($sformatf("mode%0d_frame_err", m), ferr_v[m], 1'b0);
    end

    $display("[TB] reset mid-word");
    wq.delete(); wq.push_back(8'h99);
    applyStimulus(0, wq, 0, 8'($urandom));
    tx_data = 8'($urandom);
    spiStart(0);
    spiBits(0, 8'hFF, 4, mi);
    rst_n = 1'b0;
    waitClk(2);
    checkResetOutputs("midreset");
    q.delete();
    ovrModel = 1'b0;
    rst_n = 1'b1;
    spiBits(0, 8'($urandom), 4, mi);
    checkOutput("midreset_busy_after_release", busy_v[0], 1'b0);
    spiEnd(0);
    checkFifo("midreset_stale");
    wq.delete(); wq.push_back(8'h5A);
    applyStimulus(0, wq, 0, 8'($urandom));
    checkFifo("midreset_fresh");
    popOne("midreset_pop");

    $display("[TB] random frames");
    for (int it = 0; it < 8; it++) begin
      n = $urandom_range(1, 5);
      trunc = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 7) : 0;
      wq.delete();
      for (int k = 0; k < n; k++) wq.push_back(8'($urandom));
      applyStimulus(0, wq, trunc, 8'($urandom));
      checkFifo($sformatf("rand%0d", it));
      if (ovrModel) clearErr();
      while (q.size() != 0) popOne($sformatf("rand%0d_pop", it));
    end
    checkFifo("final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
